// File: rtl/ipsxe_floating_point_fl2fl_pkg.sv
// Shared definitions for the fl2fl converter output path.
//   result_w()   : packed result width, exponent plus fraction (hidden one included).
//   ptr_w()      : FIFO pointer width for a power-of-two depth.
//   fill_w()     : fill-level width, wide enough to hold the value Depth itself.
//   TuserOvf/Unf : bit positions of the overflow/underflow flags in tuser.
package ipsxe_floating_point_fl2fl_pkg;

    localparam int unsigned TuserOvf = 1;
    localparam int unsigned TuserUnf = 0;
    localparam int unsigned TuserW   = 2;

    function automatic int unsigned result_w(input int unsigned exp_w, input int unsigned frac_w);
        return exp_w + frac_w;
    endfunction

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // One extra bit so a completely full FIFO is distinguishable from empty.
    function automatic int unsigned fill_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ipsxe_floating_point_fl2fl_obuf_ram_v1_0.sv
// Storage array for the fl2fl output buffer.
// Simple dual-port: synchronous write port, asynchronous (combinational) read port.
// Contents are never reset; validity is tracked by the owning FIFO control.
//   clk_i   : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data, combinational from raddr_i
module ipsxe_floating_point_fl2fl_obuf_ram_v1_0 #(
    parameter int unsigned Width = 66,
    parameter int unsigned Depth = 16,
    parameter int unsigned AddrW = 4
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ipsxe_floating_point_fl2fl_obuf_v1_0.sv
// Output buffer for the fl2fl converter: a first-word fall-through FIFO that absorbs
// converter results (which cannot be back-pressured) and presents them on an AXI4-Stream
// master interface. The converter is throttled by o_prog_full; any result arriving while
// the buffer is full and not being drained is dropped and flagged by sticky o_overrun.
//   i_aclk / i_areset / i_aclken : clock, synchronous active-high reset, clock enable
//   i_axi4s_result_tdata/tvalid  : converter result, no ready
//   i_overflow / i_underflow     : converter flags, qualified by tvalid
//   o_axi4s_result_tdata/tuser/tvalid, i_axi4s_result_tready : buffered output stream
//   o_prog_full                  : fill level >= PROG_FULL_THRESH
//   o_fill_level                 : current entry count, 0..FIFO_DEPTH
//   o_overrun                    : sticky, an input result was dropped
module ipsxe_floating_point_fl2fl_obuf_v1_0
    import ipsxe_floating_point_fl2fl_pkg::*;
#(
    parameter int unsigned FLOAT_OUT_EXP    = 11,
    parameter int unsigned FLOAT_OUT_FRAC   = 53,
    parameter int unsigned FIFO_DEPTH       = 16,
    parameter int unsigned PROG_FULL_THRESH = 12,
    localparam int unsigned W  = result_w(FLOAT_OUT_EXP, FLOAT_OUT_FRAC),
    localparam int unsigned CW = fill_w(FIFO_DEPTH)
) (
    input  logic              i_aclk,
    input  logic              i_areset,
    input  logic              i_aclken,
    input  logic [W-1:0]      i_axi4s_result_tdata,
    input  logic              i_axi4s_result_tvalid,
    input  logic              i_overflow,
    input  logic              i_underflow,
    output logic [W-1:0]      o_axi4s_result_tdata,
    output logic [TuserW-1:0] o_axi4s_result_tuser,
    output logic              o_axi4s_result_tvalid,
    input  logic              i_axi4s_result_tready,
    output logic              o_prog_full,
    output logic [CW-1:0]     o_fill_level,
    output logic              o_overrun
);

    localparam int unsigned AW = ptr_w(FIFO_DEPTH);
    localparam int unsigned EW = W + TuserW;

    localparam logic [AW-1:0] PtrOne  = AW'(1);
    localparam logic [CW-1:0] CntOne  = CW'(1);
    localparam logic [CW-1:0] CntFull = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CntProg = CW'(PROG_FULL_THRESH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] fill_level_q;
    logic          prog_full_q;
    logic          overrun_q, overrun_d;

    logic          head_valid;
    logic          full;
    logic          wr_en;
    logic          rd_en;
    logic          drop;
    logic          ram_we;
    logic [EW-1:0] wr_word;
    logic [EW-1:0] rd_word;

    // Handshake decode. A full FIFO still accepts a write when the head is being read in
    // the same cycle, so continuous streaming at full depth loses nothing.
    always_comb begin
        head_valid = (count_q != '0);
        full       = (count_q == CntFull);
        rd_en      = i_aclken & head_valid & i_axi4s_result_tready;
        wr_en      = i_aclken & i_axi4s_result_tvalid & (~full | rd_en);
        drop       = i_aclken & i_axi4s_result_tvalid & full & ~rd_en;
    end

    // Pointers are exactly AW bits wide, so increment wraps naturally at FIFO_DEPTH.
    always_comb begin
        wr_ptr_d  = wr_en ? (wr_ptr_q + PtrOne) : wr_ptr_q;
        rd_ptr_d  = rd_en ? (rd_ptr_q + PtrOne) : rd_ptr_q;
        overrun_d = overrun_q | drop;
        count_d   = count_q;
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    // fill_level and prog_full are registered from count_d so they line up with count_q.
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            fill_level_q <= '0;
            prog_full_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (i_aclken) begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            fill_level_q <= count_d;
            prog_full_q  <= (count_d >= CntProg);
            overrun_q    <= overrun_d;
        end
    end

    // Entry layout: {tuser, tdata}, flag positions taken from the shared tuser indices.
    always_comb begin
        wr_word                = '0;
        wr_word[W-1:0]         = i_axi4s_result_tdata;
        wr_word[W + TuserOvf]  = i_overflow;
        wr_word[W + TuserUnf]  = i_underflow;
    end

    // A result presented during reset must not land in the array either.
    assign ram_we = wr_en & ~i_areset;

    ipsxe_floating_point_fl2fl_obuf_ram_v1_0 #(
        .Width (EW),
        .Depth (FIFO_DEPTH),
        .AddrW (AW)
    ) u_ram (
        .clk_i   (i_aclk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_word),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_word)
    );

    // Head is read combinationally at rd_ptr; it only moves on a read, so the output is
    // stable while the consumer stalls.
    assign o_axi4s_result_tdata  = rd_word[W-1:0];
    assign o_axi4s_result_tuser  = rd_word[EW-1:W];
    assign o_axi4s_result_tvalid = head_valid;
    assign o_prog_full           = prog_full_q;
    assign o_fill_level          = fill_level_q;
    assign o_overrun             = overrun_q;

endmodule

// File: tb/tb_ipsxe_floating_point_fl2fl_obuf_v1_0.sv
// Bench for the fl2fl output buffer: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a queue-based model of the buffer.
module tb_ipsxe_floating_point_fl2fl_obuf_v1_0;

    localparam int unsigned Depth  = 16;
    localparam int unsigned Thresh = 12;

    logic        clk;
    logic        rst;
    logic        en;
    logic [63:0] din;
    logic        vin;
    logic        ovf;
    logic        unf;
    logic [63:0] dout;
    logic [1:0]  tuser;
    logic        vout;
    logic        rdy;
    logic        pfull;
    logic [4:0]  fill;
    logic        ovr;

    int total;
    int bad;

    // Model state: queue of {ovf, unf, data} entries and the sticky drop flag.
    logic [65:0] mq[$];
    bit          m_ovr;

    ipsxe_floating_point_fl2fl_obuf_v1_0 #(
        .FLOAT_OUT_EXP    (11),
        .FLOAT_OUT_FRAC   (53),
        .FIFO_DEPTH       (Depth),
        .PROG_FULL_THRESH (Thresh)
    ) dut (
        .i_aclk                (clk),
        .i_areset              (rst),
        .i_aclken              (en),
        .i_axi4s_result_tdata  (din),
        .i_axi4s_result_tvalid (vin),
        .i_overflow            (ovf),
        .i_underflow           (unf),
        .o_axi4s_result_tdata  (dout),
        .o_axi4s_result_tuser  (tuser),
        .o_axi4s_result_tvalid (vout),
        .i_axi4s_result_tready (rdy),
        .o_prog_full           (pfull),
        .o_fill_level          (fill),
        .o_overrun             (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit rd;
        bit wr;
        if (rst) begin
            mq.delete();
            m_ovr = 1'b0;
        end else if (en) begin
            rd = (mq.size() > 0) && rdy;
            wr = vin && ((mq.size() < Depth) || rd);
            if (rd) void'(mq.pop_front());
            if (wr) mq.push_back({ovf, unf, din});
            if (vin && !wr) m_ovr = 1'b1;
        end
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        check_eq("tvalid", 66'(vout), 66'(n != 0));
        if (n != 0) begin
            check_eq("tdata", 66'(dout), 66'(mq[0][63:0]));
            check_eq("tuser", 66'(tuser), 66'(mq[0][65:64]));
        end
        check_eq("fill_level", 66'(fill), 66'(n));
        check_eq("prog_full", 66'(pfull), 66'(n >= Thresh));
        check_eq("overrun", 66'(ovr), 66'(m_ovr));
    endtask

    // Drive one cycle of inputs while the clock is low, advance the model at the edge,
    // then compare on the falling edge.
    task automatic step(input logic r, input logic e, input logic v, input logic o,
                        input logic u, input logic [63:0] d, input logic t);
        rst = r; en = e; vin = v; ovf = o; unf = u; din = d; rdy = t;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'hDEAD, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    endtask

    logic [63:0] vals[3];
    logic [4:0]  fill_snap;
    logic [63:0] head_snap;

    initial begin
        total = 0;
        bad   = 0;
        m_ovr = 1'b0;
        rst = 1'b1; en = 1'b0; vin = 1'b0; ovf = 1'b0; unf = 1'b0; din = '0; rdy = 1'b0;
        @(negedge clk);

        // Three results buffered while stalled, then drained in order.
        do_reset();
        check_eq("reset_tvalid", 66'(vout), 66'(0));
        check_eq("reset_fill", 66'(fill), 66'(0));
        vals[0] = 64'h3FF0000000000000;
        vals[1] = 64'h4000000000000000;
        vals[2] = 64'hC008000000000000;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, vals[i], 1'b0);
        check_eq("fill3", 66'(fill), 66'(3));
        for (int i = 0; i < 3; i++) begin
            check_eq("drain_order", 66'(dout), 66'(vals[i]));
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        end
        check_eq("drained", 66'(vout), 66'(0));

        // Fill to depth, then one extra result is dropped.
        do_reset();
        for (int i = 0; i < Depth; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'(i + 100), 1'b0);
            check_eq("prog_full_ramp", 66'(pfull), 66'((i + 1) >= Thresh));
        end
        check_eq("fill16", 66'(fill), 66'(16));
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'hBAD, 1'b0);
        check_eq("drop_overrun", 66'(ovr), 66'(1));
        check_eq("drop_fill", 66'(fill), 66'(16));
        check_eq("drop_head", 66'(dout), 66'(100));

        // Full FIFO streaming through a pointer wrap.
        do_reset();
        for (int i = 0; i < Depth; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'(i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            check_eq("stream_head", 66'(dout), 66'(i));
            step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'(i + Depth), 1'b1);
            check_eq("stream_fill", 66'(fill), 66'(16));
        end
        check_eq("stream_overrun", 66'(ovr), 66'(0));

        // Overflow flag travels with its entry.
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h7FF0000000000000, 1'b0);
        check_eq("ovf_tuser", 66'(tuser), 66'(2'b10));
        check_eq("ovf_tdata", 66'(dout), 66'(64'h7FF0000000000000));

        // Clock enable low freezes everything.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h1234, 1'b0);
        fill_snap = fill;
        head_snap = dout;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h5555, 1'b1);
        check_eq("en_fill", 66'(fill), 66'(fill_snap));
        check_eq("en_head", 66'(dout), 66'(head_snap));

        // Reset while holding 7 entries with overrun set.
        do_reset();
        for (int i = 0; i < Depth + 1; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'(i), 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        check_eq("pre_reset_fill", 66'(fill), 66'(7));
        check_eq("pre_reset_ovr", 66'(ovr), 66'(1));
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'hF00D, 1'b1);
        check_eq("post_reset_tvalid", 66'(vout), 66'(0));
        check_eq("post_reset_fill", 66'(fill), 66'(0));
        check_eq("post_reset_ovr", 66'(ovr), 66'(0));

        // Randomized traffic with occasional resets and enable gaps.
        for (int i = 0; i < 3000; i++) begin
            step(1'b0 | ($urandom_range(0, 127) == 0),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom), 1'($urandom),
                 {$urandom, $urandom},
                 ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 30 : 85)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
